// File: rtl/level2pulse.sv
// level2pulse
// -----------
// Turns per-channel activity levels (for example tree-engine busy lines)
// into same-cycle start/end pulses. It also measures every high interval
// and queues one (channel, duration) record per finished interval on a
// valid/ready report stream.
//
// Ports
//   clk            rising-edge clock for all state
//   rst            synchronous active-high reset; discards every interval,
//                  pending record and queued record
//   level_i        per-channel activity level
//   start_pulse_o  one-cycle pulse in the cycle a level rises (combinational)
//   end_pulse_o    one-cycle pulse in the cycle a level falls (combinational)
//   evt_valid_o    report FIFO head is valid
//   evt_ready_i    consumer takes the head record
//   evt_ch_o       channel index of the head record
//   evt_cycles_o   high-interval length in cycles (saturating)
//   evt_sat_o      interval length saturated the counter
//   overflow_o     sticky: a finished interval was lost because its
//                  channel already held an unqueued record
//   clear_i        clears overflow_o (a drop in the same cycle wins)
module level2pulse #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] level_i,
  output logic [NUM_CH-1:0] start_pulse_o,
  output logic [NUM_CH-1:0] end_pulse_o,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [CH_W-1:0]   evt_ch_o,
  output logic [CNT_W-1:0]  evt_cycles_o,
  output logic              evt_sat_o,
  output logic              overflow_o,
  input  logic              clear_i
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Per-channel state
  logic [NUM_CH-1:0] r_prev;
  logic [CNT_W-1:0]  r_cnt     [NUM_CH];
  logic [NUM_CH-1:0] r_sat;
  logic [NUM_CH-1:0] r_pend;
  logic [CNT_W-1:0]  r_pendCnt [NUM_CH];
  logic [NUM_CH-1:0] r_pendSat;
  logic              r_overflow;

  // Report FIFO. The pointers carry one extra wrap bit so that full and
  // empty can be told apart.
  logic [CH_W-1:0]   r_fifoCh  [FIFO_DEPTH];
  logic [CNT_W-1:0]  r_fifoCnt [FIFO_DEPTH];
  logic              r_fifoSat [FIFO_DEPTH];
  logic [AW:0]       r_wrPtr;
  logic [AW:0]       r_rdPtr;

  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;
  logic [NUM_CH-1:0] w_pushMask;
  logic [CH_W-1:0]   w_pendSel;
  logic              w_anyPend;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  assign w_rise = level_i & ~r_prev;
  assign w_fall = ~level_i & r_prev;

  // Pulses are gated by rst so nothing escapes while the block is in reset.
  assign start_pulse_o = w_rise & {NUM_CH{~rst}};
  assign end_pulse_o   = w_fall & {NUM_CH{~rst}};

  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_pop   = ~w_empty & evt_ready_i & ~rst;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push  = w_anyPend & (~w_full | w_pop);

  // Fixed-priority arbiter. It walks from the highest channel down, so the
  // last hit is the lowest-index channel that has a pending record.
  always_comb begin
    w_pendSel  = '0;
    w_anyPend  = 1'b0;
    w_pushMask = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_anyPend = 1'b1;
        w_pendSel = i[CH_W-1:0];
      end
    end
    if (w_push) begin
      w_pushMask[w_pendSel] = 1'b1;
    end
  end

  // A fall is dropped only if the channel's pending slot stays occupied.
  // A slot that is being pushed this cycle is free for the new record.
  assign w_drop = |(w_fall & r_pend & ~w_pushMask);

  // Per-channel interval measurement and the pending slot. The counter
  // restarts at 1 in the rise cycle, so it always equals the number of
  // cycles the level has been high. It freezes at its maximum and sets
  // the sat flag when it would overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= '0;
      r_sat     <= '0;
      r_pend    <= '0;
      r_pendSat <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]     <= '0;
        r_pendCnt[i] <= '0;
      end
    end else begin
      r_prev <= level_i;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_rise[i]) begin
          r_cnt[i] <= CNT_W'(1);
          r_sat[i] <= 1'b0;
        end else if (level_i[i]) begin
          if (r_cnt[i] == CNT_MAX) begin
            r_sat[i] <= 1'b1;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end
        if (w_fall[i] && !(r_pend[i] && !w_pushMask[i])) begin
          r_pend[i]    <= 1'b1;
          r_pendCnt[i] <= r_cnt[i];
          r_pendSat[i] <= r_sat[i];
        end else if (w_pushMask[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow flag. A drop in the same cycle beats clear_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_i) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow_o = r_overflow;

  // Report FIFO storage and pointers. A push and a pop in the same cycle
  // are independent, because each only moves its own pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        r_fifoCh[k]  <= '0;
        r_fifoCnt[k] <= '0;
        r_fifoSat[k] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifoCh[r_wrPtr[AW-1:0]]  <= w_pendSel;
        r_fifoCnt[r_wrPtr[AW-1:0]] <= r_pendCnt[w_pendSel];
        r_fifoSat[r_wrPtr[AW-1:0]] <= r_pendSat[w_pendSel];
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
    end
  end

  // Show-ahead head. The outputs read as zero while empty or in reset.
  always_comb begin
    evt_valid_o  = 1'b0;
    evt_ch_o     = '0;
    evt_cycles_o = '0;
    evt_sat_o    = 1'b0;
    if (!w_empty && !rst) begin
      evt_valid_o  = 1'b1;
      evt_ch_o     = r_fifoCh[r_rdPtr[AW-1:0]];
      evt_cycles_o = r_fifoCnt[r_rdPtr[AW-1:0]];
      evt_sat_o    = r_fifoSat[r_rdPtr[AW-1:0]];
    end
  end

endmodule
